dram_ctrl_fpm: RTL

Initiator-side controller for the board's two banks of 16-bit FPM DRAM. It drives RAS/CAS/WE, the multiplexed address and the data bus that the bench DRAM model responds to. Internal masters issue single-word read/write requests over a req/ack/done handshake. The block also inserts CAS-before-RAS refresh on a fixed period.

---
 rtl/dram_pkg.sv | 28 ++
 rtl/dram_refresh_timer.sv | 33 +++
 rtl/dram_ctrl_fpm.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/dram_pkg.sv
// Shared types and constants for the FPM DRAM controller.
package dram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RAS,
        CAS,
        PRE,
        REF_CAS,
        REF_RAS
    } state_t;

    // Word address layout: [20]=bank, [19:10]=column, [9:0]=row
    localparam int ROW_LSB  = 0;
    localparam int COL_LSB  = 10;
    localparam int BANK_BIT = 20;
    localparam int FIELD_W  = 10;

    // Default timing, in clock cycles
    localparam int DEF_T_RCD      = 1;
    localparam int DEF_T_CAS      = 2;
    localparam int DEF_T_RP       = 2;
    localparam int DEF_REF_PERIOD = 250;

    // Width of the per-state cycle counter; covers timing values up to 16
    localparam int CNT_W = 4;

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval timer with a sticky pending flag.
module dram_refresh_timer
    import dram_pkg::*;
#(
    parameter int REF_PERIOD = DEF_REF_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic ref_pend
);

    localparam int CW = $clog2(REF_PERIOD);

    logic [CW-1:0] count;

    // Count periods; a new period end re-arms the flag even if it is being cleared
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            ref_pend <= 1'b0;
        end else if (count == CW'(REF_PERIOD - 1)) begin
            count    <= '0;
            ref_pend <= 1'b1;
        end else begin
            count <= count + CW'(1);
            if (clear) begin
                ref_pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dram_ctrl_fpm.sv
// FPM DRAM controller: single-word accesses plus periodic CAS-before-RAS refresh.
module dram_ctrl_fpm
    import dram_pkg::*;
#(
    parameter int T_RCD      = DEF_T_RCD,
    parameter int T_CAS      = DEF_T_CAS,
    parameter int T_RP       = DEF_T_RP,
    parameter int REF_PERIOD = DEF_REF_PERIOD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [20:0] addr,
    input  logic [1:0]  be,
    input  logic [15:0] wdata,
    output logic        ack,
    output logic        done,
    output logic [15:0] rdata,
    output logic        rras0_n,
    output logic        rras1_n,
    output logic        rlcas_n,
    output logic        rucas_n,
    output logic        rwe_n,
    output logic [9:0]  ra,
    output logic [15:0] rd_out,
    output logic        rd_oe,
    input  logic [15:0] rd_in
);

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               we_q;
    logic [FIELD_W-1:0] col_q;
    logic [1:0]         be_q;
    logic               latch;
    logic               ref_pend, ref_clear;

    logic               ras0_d, ras1_d, lcas_d, ucas_d, we_n_d, rd_oe_d, ack_d, done_d;
    logic [9:0]         ra_d;
    logic [15:0]        rd_out_d, rdata_d;

    dram_refresh_timer #(
        .REF_PERIOD (REF_PERIOD)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (ref_clear),
        .ref_pend (ref_pend)
    );

    // Next state and next registered outputs; every output holds unless changed
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        ras0_d    = rras0_n;
        ras1_d    = rras1_n;
        lcas_d    = rlcas_n;
        ucas_d    = rucas_n;
        we_n_d    = rwe_n;
        ra_d      = ra;
        rd_out_d  = rd_out;
        rd_oe_d   = rd_oe;
        rdata_d   = rdata;
        ack_d     = 1'b0;
        done_d    = 1'b0;
        latch     = 1'b0;
        ref_clear = 1'b0;
        case (state)
            IDLE: begin
                if (ref_pend) begin
                    state_d   = REF_CAS;
                    ref_clear = 1'b1;
                    lcas_d    = 1'b0;
                    ucas_d    = 1'b0;
                    we_n_d    = 1'b1;
                end else if (req) begin
                    state_d = RAS;
                    cnt_d   = '0;
                    latch   = 1'b1;
                    ack_d   = 1'b1;
                    ra_d    = addr[ROW_LSB +: FIELD_W];
                    ras0_d  = addr[BANK_BIT];
                    ras1_d  = ~addr[BANK_BIT];
                    we_n_d  = ~we;
                    rd_oe_d = we;
                    if (we) begin
                        rd_out_d = wdata;
                    end
                end
            end
            RAS: begin
                if (cnt == CNT_W'(T_RCD - 1)) begin
                    state_d = CAS;
                    cnt_d   = '0;
                    ra_d    = col_q;
                    lcas_d  = ~be_q[0];
                    ucas_d  = ~be_q[1];
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            CAS: begin
                if (cnt == CNT_W'(T_CAS - 1)) begin
                    state_d = PRE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    if (!we_q && be_q != 2'b00) begin
                        rdata_d = rd_in;
                    end
                    ras0_d  = 1'b1;
                    ras1_d  = 1'b1;
                    lcas_d  = 1'b1;
                    ucas_d  = 1'b1;
                    we_n_d  = 1'b1;
                    rd_oe_d = 1'b0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            PRE: begin
                if (cnt == CNT_W'(T_RP - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            REF_CAS: begin
                state_d = REF_RAS;
                cnt_d   = '0;
                ras0_d  = 1'b0;
                ras1_d  = 1'b0;
            end
            REF_RAS: begin
                if (cnt == CNT_W'(T_CAS)) begin
                    state_d = PRE;
                    cnt_d   = '0;
                    ras0_d  = 1'b1;
                    ras1_d  = 1'b1;
                    lcas_d  = 1'b1;
                    ucas_d  = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, request latches and all registered outputs; reset parks the bus idle
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            col_q   <= '0;
            be_q    <= 2'b00;
            rras0_n <= 1'b1;
            rras1_n <= 1'b1;
            rlcas_n <= 1'b1;
            rucas_n <= 1'b1;
            rwe_n   <= 1'b1;
            ra      <= '0;
            rd_out  <= '0;
            rd_oe   <= 1'b0;
            rdata   <= '0;
            ack     <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            if (latch) begin
                we_q  <= we;
                col_q <= addr[COL_LSB +: FIELD_W];
                be_q  <= be;
            end
            rras0_n <= ras0_d;
            rras1_n <= ras1_d;
            rlcas_n <= lcas_d;
            rucas_n <= ucas_d;
            rwe_n   <= we_n_d;
            ra      <= ra_d;
            rd_out  <= rd_out_d;
            rd_oe   <= rd_oe_d;
            rdata   <= rdata_d;
            ack     <= ack_d;
            done    <= done_d;
        end
    end

endmodule
